// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus SRAM responder: FSM states, access size
// encodings, the request record and the byte-lane helper functions.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [1:0]  size;
        logic        write;
        logic [63:0] wdata;
        logic        fence_i;
    } dbus_req_t;

    // Bytes covered by an access, shifted to its lane; lanes past 7 fall off.
    function automatic logic [7:0] lane_mask(input logic [2:0] offset, input logic [1:0] size);
        logic [15:0] mask;
        mask = (16'd1 << (16'd1 << size)) - 16'd1;
        mask = mask << offset;
        return mask[7:0];
    endfunction

    function automatic logic [2:0] align_mask(input size_t size);
        logic [2:0] mask;
        case (size)
            SIZE_B:  mask = 3'b000;
            SIZE_H:  mask = 3'b001;
            SIZE_W:  mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_bus.sv
// Core data bus: the master issues en/addr/size/write/wdata/fence_i/ready,
// the responder returns valid/rdata/acc_err.
interface data_bus;
    logic        en;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [63:0] wdata;
    logic        fence_i;
    logic        ready;
    logic        valid;
    logic [63:0] rdata;
    logic        acc_err;

    modport master (
        output en, addr, size, write, wdata, fence_i, ready,
        input  valid, rdata, acc_err
    );

    modport slave (
        input  en, addr, size, write, wdata, fence_i, ready,
        output valid, rdata, acc_err
    );
endinterface

// File: rtl/dbus_wstrb_gen.sv
// Byte-enable generator: turns the low address bits and access size into wstrb.
module dbus_wstrb_gen
    import dbus_pkg::*;
(
    input  logic [2:0] addr_lo,
    input  logic [1:0] size,
    output logic [7:0] wstrb
);

    assign wstrb = lane_mask(addr_lo, size);

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder bridging core loads/stores onto a req/gnt/rvalid backend.
// Define DBUS_MISALIGN_FAULT_EN to fault misaligned accesses locally.
module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter logic [63:0] ADDR_SIZE = 64'h0800_0000
) (
    input  logic        clock,
    input  logic        reset,
    data_bus.slave      d_bus,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [63:0] mem_addr,
    output logic        mem_write,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    state_t      state_q, state_d;
    logic [63:0] act_addr_q, act_addr_d;
    logic [1:0]  act_size_q, act_size_d;
    logic        act_write_q, act_write_d;
    logic [63:0] act_wdata_q, act_wdata_d;
    dbus_req_t   pend_q, pend_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic [63:0] rdata_q, rdata_d;
    logic        acc_err_q, acc_err_d;

    dbus_req_t   new_req;
    dbus_req_t   launch_req;
    logic        launch_in_range;
    logic        launch_misalign;
    logic        do_launch;

    assign new_req = '{addr: d_bus.addr, size: d_bus.size, write: d_bus.write,
                       wdata: d_bus.wdata, fence_i: d_bus.fence_i};

    // A request stored behind a flushed transaction launches when its response returns.
    assign launch_req = (state_q == WAIT && !d_bus.en) ? pend_q : new_req;

    assign launch_in_range = ({1'b0, launch_req.addr} >= {1'b0, ADDR_BASE}) &&
                             ({1'b0, launch_req.addr} < ({1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE}));

`ifdef DBUS_MISALIGN_FAULT_EN
    assign launch_misalign = |(launch_req.addr[2:0] & align_mask(size_t'(launch_req.size)));
`else
    assign launch_misalign = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            act_addr_q  <= '0;
            act_size_q  <= '0;
            act_write_q <= 1'b0;
            act_wdata_q <= '0;
            pend_q      <= '0;
            drop_q      <= 1'b0;
            valid_q     <= 1'b0;
            rdata_q     <= '0;
            acc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_addr_q  <= act_addr_d;
            act_size_q  <= act_size_d;
            act_write_q <= act_write_d;
            act_wdata_q <= act_wdata_d;
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            acc_err_q   <= acc_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        act_addr_d  = act_addr_q;
        act_size_d  = act_size_q;
        act_write_d = act_write_q;
        act_wdata_d = act_wdata_q;
        pend_d      = pend_q;
        drop_d      = drop_q;
        valid_d     = valid_q;
        rdata_d     = rdata_q;
        acc_err_d   = acc_err_q;
        do_launch   = 1'b0;

        case (state_q)
            IDLE: do_launch = d_bus.en;
            REQ: begin
                if (d_bus.en) begin
                    drop_d = 1'b1;
                    pend_d = new_req;
                end
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (drop_q || d_bus.en) begin
                        drop_d    = 1'b0;
                        do_launch = 1'b1;
                    end else begin
                        state_d   = RESP;
                        valid_d   = 1'b1;
                        rdata_d   = mem_rdata;
                        acc_err_d = mem_err;
                    end
                end else if (d_bus.en) begin
                    drop_d = 1'b1;
                    pend_d = new_req;
                end
            end
            RESP: begin
                if (d_bus.en) begin
                    do_launch = 1'b1;
                end else if (d_bus.ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Fence and faulting accesses answer locally without touching the backend.
        if (do_launch) begin
            if (launch_req.fence_i || !launch_in_range || launch_misalign) begin
                state_d   = RESP;
                valid_d   = 1'b1;
                rdata_d   = '0;
                acc_err_d = !launch_req.fence_i;
            end else begin
                state_d     = REQ;
                valid_d     = 1'b0;
                acc_err_d   = 1'b0;
                act_addr_d  = launch_req.addr;
                act_size_d  = launch_req.size;
                act_write_d = launch_req.write;
                act_wdata_d = launch_req.wdata;
            end
        end
    end

    dbus_wstrb_gen u_wstrb_gen (
        .addr_lo (act_addr_q[2:0]),
        .size    (act_size_q),
        .wstrb   (mem_wstrb)
    );

    assign mem_req       = (state_q == REQ);
    assign mem_addr      = {act_addr_q[63:3], 3'b000};
    assign mem_write     = act_write_q;
    assign mem_wdata     = act_wdata_q;
    assign d_bus.valid   = valid_q;
    assign d_bus.rdata   = rdata_q;
    assign d_bus.acc_err = acc_err_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed self-checking bench for dbus_sram_responder; the backend is driven by hand.
module tb_dbus_sram_responder;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic        mem_gnt;
    logic [63:0] mem_addr;
    logic        mem_write;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;

    int tests_run;
    int tests_failed;

    data_bus d_bus ();

    dbus_sram_responder dut (
        .clock      (clock),
        .reset      (reset),
        .d_bus      (d_bus),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [63:0] addr, input logic [1:0] size,
                             input logic write, input logic [63:0] wdata, input logic fence);
        d_bus.en      = 1'b1;
        d_bus.addr    = addr;
        d_bus.size    = size;
        d_bus.write   = write;
        d_bus.wdata   = wdata;
        d_bus.fence_i = fence;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests_run++; if (d_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %0b expected 0", d_bus.valid); end
        tests_run++; if (d_bus.acc_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_acc_err: got %0b expected 0", d_bus.acc_err); end
        tests_run++; if (d_bus.rdata !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 0", d_bus.rdata); end
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %0b expected 0", mem_req); end
    endtask

    task automatic test_load();
        drive_req(64'h8000_0010, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        d_bus.en = 1'b0;
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_req: got %0b expected 1", mem_req); end
        tests_run++; if (mem_addr !== 64'h8000_0010) begin tests_failed++; $display("[TB] FAIL load_addr: got %h expected 8000_0010", mem_addr); end
        tests_run++; if (mem_write !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_write: got %0b expected 0", mem_write); end
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1122_3344_5566_7788;
        tests_run++; if (d_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_early_valid: got %0b expected 0", d_bus.valid); end
        step();
        mem_rvalid = 1'b0;
        tests_run++; if (d_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_valid_lat3: got %0b expected 1", d_bus.valid); end
        tests_run++; if (d_bus.rdata !== 64'h1122_3344_5566_7788) begin tests_failed++; $display("[TB] FAIL load_rdata: got %h expected 1122334455667788", d_bus.rdata); end
        tests_run++; if (d_bus.acc_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_acc_err: got %0b expected 0", d_bus.acc_err); end
        d_bus.ready = 1'b1;
        step();
        d_bus.ready = 1'b0;
        tests_run++; if (d_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_consumed: got %0b expected 0", d_bus.valid); end
    endtask

    task automatic test_store_strobes();
        logic [63:0] addrs [4] = '{64'h8000_0005, 64'h8000_0006, 64'h8000_0004, 64'h8000_0018};
        logic [1:0]  sizes [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [63:0] words [4] = '{64'hAB << 40, 64'hBEEF << 48, 64'hCAFE_F00D << 32, 64'h0123_4567_89AB_CDEF};
        logic [63:0] exp_a [4] = '{64'h8000_0000, 64'h8000_0000, 64'h8000_0000, 64'h8000_0018};
        logic [7:0]  exp_s [4] = '{8'h20, 8'hC0, 8'hF0, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            drive_req(addrs[i], sizes[i], 1'b1, words[i], 1'b0);
            step();
            d_bus.en = 1'b0;
            // hold grant off for a cycle so request stability is visible
            step();
            tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL store%0d_req_held: got %0b expected 1", i, mem_req); end
            tests_run++; if (mem_addr !== exp_a[i]) begin tests_failed++; $display("[TB] FAIL store%0d_addr: got %h expected %h", i, mem_addr, exp_a[i]); end
            tests_run++; if (mem_wstrb !== exp_s[i]) begin tests_failed++; $display("[TB] FAIL store%0d_wstrb: got %h expected %h", i, mem_wstrb, exp_s[i]); end
            tests_run++; if (mem_write !== 1'b1) begin tests_failed++; $display("[TB] FAIL store%0d_write: got %0b expected 1", i, mem_write); end
            tests_run++; if (mem_wdata !== words[i]) begin tests_failed++; $display("[TB] FAIL store%0d_wdata: got %h expected %h", i, mem_wdata, words[i]); end
            mem_gnt = 1'b1;
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_err    = (i == 3);
            tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL store%0d_req_drop: got %0b expected 0", i, mem_req); end
            step();
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            tests_run++; if (d_bus.acc_err !== (i == 3)) begin tests_failed++; $display("[TB] FAIL store%0d_acc_err: got %0b expected %0b", i, d_bus.acc_err, (i == 3)); end
            d_bus.ready = 1'b1;
            step();
            d_bus.ready = 1'b0;
        end
    endtask

    task automatic test_local_responses();
        logic [63:0] addrs [5] = '{64'h0000_1000, 64'h7FFF_FFFF, 64'h8800_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0040};
        logic        fences [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          req_seen;
        for (int i = 0; i < 5; i++) begin
            req_seen = 0;
            drive_req(addrs[i], (i == 3) ? 2'd0 : 2'd2, 1'b0, 64'h0, fences[i]);
            step();
            d_bus.en      = 1'b0;
            d_bus.fence_i = 1'b0;
            req_seen += int'(mem_req);
            tests_run++; if (d_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL local%0d_valid: got %0b expected 1", i, d_bus.valid); end
            tests_run++; if (d_bus.acc_err !== !fences[i]) begin tests_failed++; $display("[TB] FAIL local%0d_acc_err: got %0b expected %0b", i, d_bus.acc_err, !fences[i]); end
            d_bus.ready = 1'b1;
            step();
            d_bus.ready = 1'b0;
            req_seen += int'(mem_req);
            tests_run++; if (req_seen != 0) begin tests_failed++; $display("[TB] FAIL local%0d_no_backend: got %0d req cycles expected 0", i, req_seen); end
        end
        // last byte of the window is still decoded
        drive_req(64'h87FF_FFFF, 2'd0, 1'b0, 64'h0, 1'b0);
        step();
        d_bus.en = 1'b0;
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL top_byte_req: got %0b expected 1", mem_req); end
        tests_run++; if (mem_wstrb !== 8'h80) begin tests_failed++; $display("[TB] FAIL top_byte_wstrb: got %h expected 80", mem_wstrb); end
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid  = 1'b0;
        d_bus.ready = 1'b1;
        step();
        d_bus.ready = 1'b0;
    endtask

    task automatic test_supersede();
        int valid_seen;
        valid_seen = 0;
        drive_req(64'h8000_0100, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        d_bus.en = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        valid_seen += int'(d_bus.valid);
        drive_req(64'h8000_0200, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        d_bus.en = 1'b0;
        valid_seen += int'(d_bus.valid);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hAAAA;
        step();
        mem_rvalid = 1'b0;
        valid_seen += int'(d_bus.valid);
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL supersede_req: got %0b expected 1", mem_req); end
        tests_run++; if (mem_addr !== 64'h8000_0200) begin tests_failed++; $display("[TB] FAIL supersede_addr: got %h expected 8000_0200", mem_addr); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        valid_seen += int'(d_bus.valid);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hBBBB;
        step();
        mem_rvalid = 1'b0;
        valid_seen += int'(d_bus.valid);
        tests_run++; if (d_bus.rdata !== 64'hBBBB) begin tests_failed++; $display("[TB] FAIL supersede_rdata: got %h expected BBBB", d_bus.rdata); end
        d_bus.ready = 1'b1;
        step();
        d_bus.ready = 1'b0;
        valid_seen += int'(d_bus.valid);
        tests_run++; if (valid_seen != 1) begin tests_failed++; $display("[TB] FAIL supersede_one_valid: got %0d expected 1", valid_seen); end

        // two flushes while in REQ: the later request wins
        drive_req(64'h8000_0300, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        drive_req(64'h8000_0400, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        drive_req(64'h8000_0500, 2'd3, 1'b0, 64'h0, 1'b0);
        mem_gnt = 1'b1;
        step();
        d_bus.en   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        tests_run++; if (mem_addr !== 64'h8000_0500) begin tests_failed++; $display("[TB] FAIL pending_overwrite_addr: got %h expected 8000_0500", mem_addr); end
        tests_run++; if (d_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL pending_overwrite_valid: got %0b expected 0", d_bus.valid); end
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid  = 1'b0;
        d_bus.ready = 1'b1;
        step();
        d_bus.ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_req(64'h8000_0020, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        d_bus.en = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h5555_6666_7777_8888;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (d_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold%0d_valid: got %0b expected 1", i, d_bus.valid); end
            tests_run++; if (d_bus.rdata !== 64'h5555_6666_7777_8888) begin tests_failed++; $display("[TB] FAIL hold%0d_rdata: got %h expected 5555666677778888", i, d_bus.rdata); end
            step();
        end
        d_bus.ready = 1'b1;
        drive_req(64'h8000_0040, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        d_bus.en    = 1'b0;
        d_bus.ready = 1'b0;
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_req: got %0b expected 1", mem_req); end
        tests_run++; if (mem_addr !== 64'h8000_0040) begin tests_failed++; $display("[TB] FAIL b2b_addr: got %h expected 8000_0040", mem_addr); end
        tests_run++; if (d_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_valid: got %0b expected 0", d_bus.valid); end
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        // new en in RESP without ready drops the held response
        drive_req(64'h8000_0048, 2'd3, 1'b0, 64'h0, 1'b0);
        step();
        d_bus.en = 1'b0;
        tests_run++; if (d_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL resp_supersede_valid: got %0b expected 0", d_bus.valid); end
        tests_run++; if (mem_addr !== 64'h8000_0048) begin tests_failed++; $display("[TB] FAIL resp_supersede_addr: got %h expected 8000_0048", mem_addr); end
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid  = 1'b0;
        d_bus.ready = 1'b1;
        step();
        d_bus.ready = 1'b0;
    endtask

    task automatic test_misalign();
        drive_req(64'h8000_0001, 2'd1, 1'b1, 64'h0000_0000_00CD_EF00, 1'b0);
        step();
        d_bus.en = 1'b0;
`ifdef DBUS_MISALIGN_FAULT_EN
        tests_run++; if (d_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_valid: got %0b expected 1", d_bus.valid); end
        tests_run++; if (d_bus.acc_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_acc_err: got %0b expected 1", d_bus.acc_err); end
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL misalign_req: got %0b expected 0", mem_req); end
`else
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_req: got %0b expected 1", mem_req); end
        tests_run++; if (mem_wstrb !== 8'h06) begin tests_failed++; $display("[TB] FAIL misalign_wstrb: got %h expected 06", mem_wstrb); end
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        tests_run++; if (d_bus.acc_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL misalign_acc_err: got %0b expected 0", d_bus.acc_err); end
`endif
        d_bus.ready = 1'b1;
        step();
        d_bus.ready = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        d_bus.en      = 1'b0;
        d_bus.addr    = '0;
        d_bus.size    = '0;
        d_bus.write   = 1'b0;
        d_bus.wdata   = '0;
        d_bus.fence_i = 1'b0;
        d_bus.ready   = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        mem_err       = 1'b0;
        test_reset();
        test_load();
        test_store_strobes();
        test_local_responses();
        test_supersede();
        test_back_to_back();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h8000_0000, meaning the lowest decoded byte address.
REQ-002 SHALL have parameter ADDR_SIZE, default 64'h0800_0000, meaning the decoded window length in bytes.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port d_bus  data_bus.slave  -  responder end of the core data bus: en, addr[63:0], size[1:0], write, wdata[63:0], fence_i, ready in; valid, rdata[63:0], acc_err out.
REQ-006 SHALL have port mem_req  output  1  backend request, held until granted.
REQ-007 SHALL have port mem_gnt  input  1  backend accepted the request this cycle.
REQ-008 SHALL have port mem_addr  output  64  backend address, 8-byte aligned.
REQ-009 SHALL have port mem_write  output  1  backend write.
REQ-010 SHALL have port mem_wdata  output  64  backend write data, lane-positioned.
REQ-011 SHALL have port mem_wstrb  output  8  backend byte enables.
REQ-012 SHALL have port mem_rvalid  input  1  backend response, one per granted request, in order.
REQ-013 SHALL have port mem_rdata  input  64  backend read word.
REQ-014 SHALL have port mem_err  input  1  backend error, qualified by mem_rvalid.

Function
REQ-015 SHALL capture addr, size, write, wdata and fence_i on every cycle with d_bus.en high, and SHALL treat d_bus.valid && d_bus.ready as response consumption.
REQ-016 SHALL use states IDLE, REQ, WAIT and RESP; transitions: IDLE/RESP+consume --en--> REQ; REQ --mem_gnt--> WAIT; WAIT --mem_rvalid--> RESP; RESP --ready, no en--> IDLE.
REQ-017 SHALL assert mem_req only in REQ, keeping mem_addr, mem_write, mem_wdata and mem_wstrb stable until mem_gnt.
REQ-018 SHALL set mem_addr to {addr[63:3],3'b0} and mem_wstrb to ((1<<(1<<size))-1)<<addr[2:0], truncated to 8 bits; size encoding: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
REQ-019 SHALL return rdata as the raw 64-bit backend word, leaving lane extraction to the master; rdata is don't-care for writes.
REQ-020 SHALL register the backend response, so valid rises the cycle after mem_rvalid; minimum load latency is 3 cycles from en to valid with zero-wait mem_gnt and mem_rvalid.
REQ-021 SHALL hold valid, rdata and acc_err stable in RESP until ready.
REQ-022 SHALL complete without any backend access, with valid the cycle after en, when the address is outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE), with acc_err=1; the comparison uses 64-bit arithmetic without wrap.
REQ-023 SHALL treat fence_i the same way, returning valid the cycle after en with acc_err=0.
REQ-024 SHALL set acc_err=1 when mem_rvalid arrives with mem_err=1.
REQ-025 SHALL treat en arriving in REQ or WAIT as a superseding request after a master flush: it SHALL mark the in-flight transaction as dropped, store the new request in a one-entry pending register, finish the in-flight backend handshake, discard its response without asserting valid, and then issue the pending request.
REQ-026 SHALL treat a second superseding en while a request is pending as overwriting the pending entry, which is last-writer-wins.
REQ-027 SHALL treat en in RESP without ready as superseding: the held response is dropped and the new request is processed.
REQ-028 SHALL treat en with ready in RESP as back-to-back: it consumes the old response and enters REQ the next cycle with no bubble.

Reset
REQ-029 SHALL, on reset, go to IDLE, clear the pending entry and drop flag, and drive valid=0, acc_err=0, rdata=0 and mem_req=0; reset mid-transaction abandons it, and the backend is reset together with this block.

Configuration
REQ-030 SHALL, with DBUS_MISALIGN_FAULT_EN defined, return acc_err=1 with no backend access, valid the cycle after en, for any access where addr is not a multiple of 1<<size; without the macro, misaligned accesses proceed and mem_wstrb bits beyond lane 7 are discarded.

Structure
REQ-031 SHALL keep the state enum, the size encodings and the lane-mask function in the shared package dbus_pkg.
REQ-032 SHALL place strobe generation in sub-module dbus_wstrb_gen, taking addr[2:0] and size and producing wstrb[7:0].

Verification
REQ-033 SHALL cover: ld 8 B at 0x8000_0010, mem_gnt and mem_rvalid zero-wait, rdata 0x1122334455667788 -> valid 3 cycles after en, rdata identical, acc_err 0.
REQ-034 SHALL cover: sb addr 0x8000_0005, wdata 0xAB<<40 -> mem_addr 0x8000_0000, mem_wstrb 8'h20, mem_write 1.
REQ-035 SHALL cover: lw at 0x0000_1000 -> valid next cycle, acc_err 1, mem_req never asserted.
REQ-036 SHALL cover: en for A, then en for B during WAIT, A response 0xAAAA, B response 0xBBBB -> exactly one valid, rdata 0xBBBB.
REQ-037 SHALL cover: ready low 5 cycles in RESP -> valid and rdata stable; then ready together with new en -> mem_req asserted the next cycle.
REQ-038 SHALL cover: with DBUS_MISALIGN_FAULT_EN, lh at 0x8000_0001 -> acc_err 1; without the macro -> mem_wstrb 8'h06.
